// File: rtl/conv_window_ctrl.sv
// ---------------------------------------------------------------------------
// ConvWindowCtrl -- raster-scan window controller for a conv + pool stage.
//
// Tracks the (row, col) position of the next expected pixel of an N x N
// feature map. For every accepted pixel it raises conv_valid_o when a full
// conv_size x conv_size window has closed, and pool_valid_o when that conv
// output also completes a 2x2 pooling block. Both strobes appear one cycle
// after the pixel that caused them.
//
// Ports
//   clk             rising-edge clock
//   rst_n           asynchronous active-low reset
//   start_i         one-cycle frame request (honoured only when idle)
//   featmap_size_i  map edge N, sampled when start_i is accepted
//   din_valid_i     one raster-order pixel presented this cycle
//   abort_i         synchronous frame cancel
//   busy_o          frame in progress
//   row_o, col_o    position of the next expected pixel
//   conv_valid_o    conv window completed by the previous accepted pixel
//   pool_valid_o    that conv output also closed a pooling block
//   frame_done_o    one-cycle pulse after the last pixel of a frame
//   cfg_err_o       one-cycle pulse when start_i carried an illegal size
// ---------------------------------------------------------------------------
module conv_window_ctrl #(
    parameter int conv_size    = 3,
    parameter int pooling_size = 2,   // only 2 is supported
    parameter int max_featmap  = 30
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start_i,
    input  logic [4:0] featmap_size_i,
    input  logic       din_valid_i,
    input  logic       abort_i,
    output logic       busy_o,
    output logic [4:0] row_o,
    output logic [4:0] col_o,
    output logic       conv_valid_o,
    output logic       pool_valid_o,
    output logic       frame_done_o,
    output logic       cfg_err_o
);

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_e;

    localparam logic [4:0] KSize = 5'(conv_size);
    localparam logic [4:0] KM1   = 5'(conv_size - 1);
    localparam logic [4:0] PSize = 5'(pooling_size);
    localparam logic [4:0] PM1   = 5'(pooling_size - 1);
    localparam logic [4:0] MaxN  = 5'(max_featmap);

    state_e     state_q, state_d;
    logic [4:0] n_q, n_d;
    logic [4:0] row_q, row_d;
    logic [4:0] col_q, col_d;
    logic       conv_q, conv_d;
    logic       pool_q, pool_d;
    logic       done_q, done_d;
    logic       cfg_err_q, cfg_err_d;

    logic       sizeOk;
    logic [4:0] nM1;
    logic       lastCol;
    logic       lastRow;
    logic       convFlag;
    logic       poolFlag;
    logic [4:0] oy;
    logic [4:0] ox;
    logic [4:0] outEdge;
    logic [4:0] poolSpan;

    assign sizeOk  = (featmap_size_i >= KSize) && (featmap_size_i <= MaxN);
    assign nM1     = n_q - 5'd1;
    assign lastCol = (col_q == nM1);
    assign lastRow = (row_q == nM1);

    // oy/ox are only meaningful when convFlag holds, so the wrap of the
    // subtraction for early rows/cols never reaches poolFlag.
    assign convFlag = (row_q >= KM1) && (col_q >= KM1);
    assign oy       = row_q - KM1;
    assign ox       = col_q - KM1;
    assign outEdge  = n_q - KM1;
    // An odd number of conv outputs leaves a last row/column that never
    // fills a pooling block, so the usable span is rounded down.
    assign poolSpan = outEdge - (outEdge % PSize);
    assign poolFlag = convFlag
                   && ((oy % PSize) == PM1) && ((ox % PSize) == PM1)
                   && (oy < poolSpan) && (ox < poolSpan);

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            n_q       <= 5'd0;
            row_q     <= 5'd0;
            col_q     <= 5'd0;
            conv_q    <= 1'b0;
            pool_q    <= 1'b0;
            done_q    <= 1'b0;
            cfg_err_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            n_q       <= n_d;
            row_q     <= row_d;
            col_q     <= col_d;
            conv_q    <= conv_d;
            pool_q    <= pool_d;
            done_q    <= done_d;
            cfg_err_q <= cfg_err_d;
        end
    end

    // Next-state logic; abort outranks both pixel acceptance and frame end.
    always_comb begin
        state_d   = state_q;
        n_d       = n_q;
        row_d     = row_q;
        col_d     = col_q;
        conv_d    = 1'b0;
        pool_d    = 1'b0;
        done_d    = 1'b0;
        cfg_err_d = 1'b0;
        case (state_q)
            IDLE: begin
                if (start_i) begin
                    if (sizeOk) begin
                        state_d = RUN;
                        n_d     = featmap_size_i;
                        row_d   = 5'd0;
                        col_d   = 5'd0;
                    end else begin
                        cfg_err_d = 1'b1;
                    end
                end
            end
            RUN: begin
                if (abort_i) begin
                    state_d = IDLE;
                    row_d   = 5'd0;
                    col_d   = 5'd0;
                end else if (din_valid_i) begin
                    conv_d = convFlag;
                    pool_d = poolFlag;
                    if (lastRow && lastCol) begin
                        state_d = IDLE;
                        done_d  = 1'b1;
                        row_d   = 5'd0;
                        col_d   = 5'd0;
                    end else if (lastCol) begin
                        col_d = 5'd0;
                        row_d = row_q + 5'd1;
                    end else begin
                        col_d = col_q + 5'd1;
                    end
                end
            end
        endcase
    end

    // Outputs
    always_comb begin
        busy_o       = (state_q == RUN);
        row_o        = row_q;
        col_o        = col_q;
        conv_valid_o = conv_q;
        pool_valid_o = pool_q;
        frame_done_o = done_q;
        cfg_err_o    = cfg_err_q;
    end

endmodule

// File: doc/conv_window_ctrl.md
CONV_WINDOW_CTRL -- requirements
Module: conv_window_ctrl

Interface
REQ-001 Parameter conv_size, default 3: convolution kernel edge, stride 1.
REQ-002 Parameter pooling_size, default 2: pooling window edge, stride 2; only 2 is supported.
REQ-003 Parameter max_featmap, default 30: largest accepted input feature-map edge.
REQ-004 clk  input  1  single clock; all logic on rising edge.
REQ-005 rst_n  input  1  reset, asynchronous, active-low.
REQ-006 start  input  1  one-cycle request to begin a frame.
REQ-007 featmap_size  input  5  input map edge N, sampled only when start is accepted.
REQ-008 din_valid  input  1  one raster-order pixel presented this cycle.
REQ-009 abort  input  1  synchronous frame cancel.
REQ-010 busy  output  1  frame in progress.
REQ-011 row  output  5  row of next expected pixel.
REQ-012 col  output  5  column of next expected pixel.
REQ-013 conv_valid  output  1  a full conv window completed at the previous accepted pixel.
REQ-014 pool_valid  output  1  conv output completing a 2x2 pooling block.
REQ-015 frame_done  output  1  one-cycle pulse at normal end of frame.
REQ-016 cfg_err  output  1  one-cycle pulse when start carries an illegal size.

Function
REQ-017 States: IDLE and RUN only; busy SHALL be 1 exactly in RUN.
REQ-018 IDLE with start=1: if conv_size <= featmap_size <= max_featmap, latch N, clear row/col, enter RUN next cycle; otherwise pulse cfg_err next cycle and stay IDLE.
REQ-019 In IDLE, din_valid SHALL be ignored, with no counting and no strobes.
REQ-020 In RUN, start SHALL be ignored, and cfg_err SHALL NOT fire.
REQ-021 RUN: each din_valid=1 cycle accepts one pixel; col increments, and at col=N-1 wraps to 0 with row incrementing; din_valid=0 holds the counters (gaps allowed).
REQ-022 Each strobe's flag is computed from the accepted pixel's (row,col) and registered: 1-cycle latency, high for exactly one cycle per qualifying pixel.
REQ-023 conv_valid flag: row >= conv_size-1 and col >= conv_size-1.
REQ-024 Let oy=row-(conv_size-1), ox=col-(conv_size-1), O=N-conv_size+1, P=2*floor(O/2). The pool_valid flag requires the conv_valid flag, oy and ox both odd, oy < P and ox < P; odd O drops the last output row and column.
REQ-025 Accepting the pixel at (N-1,N-1) SHALL pulse frame_done the next cycle, coincident with the final conv_valid, and return to IDLE in that same cycle (busy=0, row=col=0).
REQ-026 abort=1 in RUN SHALL return to IDLE next cycle and clear the counters, with no frame_done and no strobes for a pixel accepted that cycle.
REQ-027 abort has priority over din_valid and over last-pixel completion; abort in IDLE has no effect, and abort with start in IDLE makes start win.
REQ-028 start may be accepted in the cycle after frame_done, giving back-to-back frames with no lost pixel.
REQ-029 Counter widths SHALL be 5 bits; no arithmetic overflow is permitted for N <= max_featmap.

Reset
REQ-030 rst_n=0 SHALL force IDLE immediately, with busy, conv_valid, pool_valid, frame_done, cfg_err, row and col all 0 and the latched N cleared.
REQ-031 Reset mid-frame SHALL discard the frame; no pulse may be emitted after rst_n deasserts until a new start.

Verification
REQ-032 start with N=30, then 900 contiguous din_valid -> 784 conv_valid, 196 pool_valid, 1 frame_done 1 cycle after the last pixel, busy low after it.
REQ-033 start with N=14, din_valid at 50% duty with random gaps -> 144 conv_valid, 36 pool_valid; first conv_valid 1 cycle after pixel (2,2); row/col hold during gaps.
REQ-034 start with N=5 -> 9 conv_valid, 1 pool_valid (after pixel (3,3)); start with N=2 or N=31 -> cfg_err pulse, busy stays 0.
REQ-035 abort after 100 pixels of an N=30 frame -> busy=0 next cycle, no frame_done; a following full frame gives the counts from REQ-032.
REQ-036 rst_n asserted mid-frame, start held high in RUN, and din_valid in IDLE -> outputs go to 0 asynchronously; start in RUN is ignored; no counting occurs in IDLE.
REQ-037 Two back-to-back N=14 frames with start in the frame_done cycle -> 2 frame_done pulses and 288 conv_valid in total.
